// File: rtl/osd_pkg.sv
// Shared constants, FSM state encoding and command record for the OSD row writer.
// The register map and row geometry mirror the OSD generator's Avalon-MM slave.
package osd_pkg;

    localparam int CHAR_ROWS     = 30;
    localparam int CHAR_COLS     = 16;
    localparam int WORDS_PER_ROW = 8;
    localparam int WORDS_PER_SEC = CHAR_COLS / 4;
    localparam int ROW_W         = 5;
    localparam int DATA_W        = 32;

    localparam logic [7:0] CFG_ADDR     = 8'hF0;
    localparam logic [7:0] LSEC_EN_ADDR = 8'hF1;
    localparam logic [7:0] RSEC_EN_ADDR = 8'hF2;
    localparam logic [7:0] COLOR_ADDR   = 8'hF3;

    localparam int RENDER_EN      = 0;
    localparam int STATUS_REFRESH = 1;
    localparam int MENU_ACTIVE    = 2;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_WR_CHAR,
        ST_RD_EN,
        ST_WR_EN,
        ST_RD_COL,
        ST_WR_COL,
        ST_RD_CFG,
        ST_WR_CFG,
        ST_DONE
    } osd_state_e;

    typedef struct packed {
        logic [ROW_W-1:0] row;
        logic             sec;
        logic             en;
        logic             hilite;
        logic             refresh;
    } row_cmd_t;

    // row*8 + sec*4 + w collapses to a plain concatenation for an 8-word row stride.
    function automatic logic [7:0] char_word_addr(input logic [ROW_W-1:0] row,
                                                  input logic             sec,
                                                  input logic [1:0]       w);
        return {row, sec, w};
    endfunction

endpackage

// File: rtl/osd_rmw_bit.sv
// Single-bit read-modify-write engine: the read phase captures the register,
// the write phase returns it with one bit replaced. The caller sequences the phases.
module osd_rmw_bit
    import osd_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              rd_req_i,
    input  logic              wr_req_i,
    input  logic [7:0]        addr_i,
    input  logic [ROW_W-1:0]  bit_idx_i,
    input  logic              bit_val_i,
    input  logic [DATA_W-1:0] rdata_i,
    input  logic              waitreq_i,
    output logic              read_o,
    output logic              write_o,
    output logic [7:0]        address_o,
    output logic [DATA_W-1:0] wdata_o,
    output logic              rd_done_o,
    output logic              wr_done_o
);

    logic [DATA_W-1:0] data_q, data_d;
    logic [DATA_W-1:0] bit_mask;
    logic [DATA_W-1:0] merged;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign bit_mask = {{(DATA_W-1){1'b0}}, 1'b1} << bit_idx_i;
    assign merged   = bit_val_i ? (data_q | bit_mask) : (data_q & ~bit_mask);

    always_comb begin
        data_d = data_q;
        if (rd_req_i && !waitreq_i) begin
            data_d = rdata_i;
        end
    end

    // Bus-facing outputs stay at zero unless a phase is active.
    assign read_o    = rd_req_i;
    assign write_o   = wr_req_i;
    assign address_o = (rd_req_i || wr_req_i) ? addr_i : 8'h00;
    assign wdata_o   = wr_req_i ? merged : '0;
    assign rd_done_o = rd_req_i && !waitreq_i;
    assign wr_done_o = wr_req_i && !waitreq_i;

endmodule

// File: rtl/osd_row_writer.sv
// Avalon-MM master that writes one 16-character OSD row section and then updates
// the row-enable, row-color and (optionally) config registers by read-modify-write.
module osd_row_writer
    import osd_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ROW_W-1:0]  cmd_row,
    input  logic              cmd_sec,
    input  logic              cmd_en,
    input  logic              cmd_hilite,
    input  logic              cmd_refresh,
    input  logic              char_valid,
    output logic              char_ready,
    input  logic [7:0]        char_data,
    output logic [7:0]        avm_address,
    output logic              avm_write,
    output logic              avm_read,
    output logic [DATA_W-1:0] avm_writedata,
    output logic [3:0]        avm_byteenable,
    input  logic [DATA_W-1:0] avm_readdata,
    input  logic              avm_waitrequest,
    output logic              busy,
    output logic              done,
    output logic              err
);

    osd_state_e        state_q, state_d;
    row_cmd_t          cmd_q, cmd_d;
    logic [DATA_W-1:0] word_q, word_d;
    logic [1:0]        char_idx_q, char_idx_d;
    logic [1:0]        word_idx_q, word_idx_d;
    logic              err_q, err_d;

    logic              rmw_rd, rmw_wr, rmw_val;
    logic [7:0]        rmw_addr;
    logic [ROW_W-1:0]  rmw_idx;
    logic              rmw_read, rmw_write, rmw_rd_done, rmw_wr_done;
    logic [7:0]        rmw_address;
    logic [DATA_W-1:0] rmw_wdata;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            cmd_q      <= '0;
            word_q     <= '0;
            char_idx_q <= '0;
            word_idx_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            word_q     <= word_d;
            char_idx_q <= char_idx_d;
            word_idx_q <= word_idx_d;
            err_q      <= err_d;
        end
    end

    // Which register the shared read-modify-write engine targets in each phase.
    always_comb begin
        rmw_rd   = 1'b0;
        rmw_wr   = 1'b0;
        rmw_addr = LSEC_EN_ADDR;
        rmw_idx  = cmd_q.row;
        rmw_val  = cmd_q.en;
        case (state_q)
            ST_RD_EN, ST_WR_EN: begin
                rmw_rd   = (state_q == ST_RD_EN);
                rmw_wr   = (state_q == ST_WR_EN);
                rmw_addr = cmd_q.sec ? RSEC_EN_ADDR : LSEC_EN_ADDR;
            end
            ST_RD_COL, ST_WR_COL: begin
                rmw_rd   = (state_q == ST_RD_COL);
                rmw_wr   = (state_q == ST_WR_COL);
                rmw_addr = COLOR_ADDR;
                rmw_val  = cmd_q.hilite;
            end
            ST_RD_CFG, ST_WR_CFG: begin
                rmw_rd   = (state_q == ST_RD_CFG);
                rmw_wr   = (state_q == ST_WR_CFG);
                rmw_addr = CFG_ADDR;
                rmw_idx  = ROW_W'(STATUS_REFRESH);
                rmw_val  = 1'b1;
            end
            default: ;
        endcase
    end

    osd_rmw_bit u_rmw (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .rd_req_i  (rmw_rd),
        .wr_req_i  (rmw_wr),
        .addr_i    (rmw_addr),
        .bit_idx_i (rmw_idx),
        .bit_val_i (rmw_val),
        .rdata_i   (avm_readdata),
        .waitreq_i (avm_waitrequest),
        .read_o    (rmw_read),
        .write_o   (rmw_write),
        .address_o (rmw_address),
        .wdata_o   (rmw_wdata),
        .rd_done_o (rmw_rd_done),
        .wr_done_o (rmw_wr_done)
    );

    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        word_d     = word_q;
        char_idx_d = char_idx_q;
        word_idx_d = word_idx_q;
        err_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    cmd_d = '{row: cmd_row, sec: cmd_sec, en: cmd_en,
                              hilite: cmd_hilite, refresh: cmd_refresh};
                    if (int'(cmd_row) >= CHAR_ROWS) begin
                        err_d = 1'b1;
                    end else begin
                        state_d    = ST_COLLECT;
                        char_idx_d = '0;
                        word_idx_d = '0;
                    end
                end
            end
            ST_COLLECT: begin
                if (char_valid) begin
                    word_d[{char_idx_q, 3'b000} +: 8] = char_data;
                    char_idx_d = char_idx_q + 2'd1;
                    if (char_idx_q == 2'd3) begin
                        state_d = ST_WR_CHAR;
                    end
                end
            end
            ST_WR_CHAR: begin
                if (!avm_waitrequest) begin
                    word_idx_d = word_idx_q + 2'd1;
                    state_d    = (word_idx_q == 2'(WORDS_PER_SEC - 1)) ? ST_RD_EN : ST_COLLECT;
                end
            end
            ST_RD_EN:  if (rmw_rd_done) state_d = ST_WR_EN;
            ST_WR_EN:  if (rmw_wr_done) state_d = ST_RD_COL;
            ST_RD_COL: if (rmw_rd_done) state_d = ST_WR_COL;
            ST_WR_COL: if (rmw_wr_done) state_d = cmd_q.refresh ? ST_RD_CFG : ST_DONE;
            ST_RD_CFG: if (rmw_rd_done) state_d = ST_WR_CFG;
            ST_WR_CFG: if (rmw_wr_done) state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Character-word writes own the bus in WR_CHAR; every other phase belongs to the engine.
    always_comb begin
        avm_address   = rmw_address;
        avm_read      = rmw_read;
        avm_write     = rmw_write;
        avm_writedata = rmw_wdata;
        if (state_q == ST_WR_CHAR) begin
            avm_address   = char_word_addr(cmd_q.row, cmd_q.sec, word_idx_q);
            avm_read      = 1'b0;
            avm_write     = 1'b1;
            avm_writedata = word_q;
        end
        avm_byteenable = (avm_read || avm_write) ? 4'hF : 4'h0;
    end

    // Ready is masked by reset so every output reads zero while reset is held.
    assign cmd_ready  = rst_ni && (state_q == ST_IDLE);
    assign char_ready = (state_q == ST_COLLECT);
    assign busy       = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign done       = (state_q == ST_DONE);
    assign err        = err_q;

endmodule

// File: tb/tb_osd_row_writer.sv
// Self-checking bench for osd_row_writer: an Avalon-MM slave model with stall
// injection, a character stream driver and a register-level reference model.
module tb_osd_row_writer;
    import osd_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [4:0]  cmd_row = '0;
    logic        cmd_sec = 1'b0, cmd_en = 1'b0, cmd_hilite = 1'b0, cmd_refresh = 1'b0;
    logic        char_valid = 1'b0;
    logic        char_ready;
    logic [7:0]  char_data = '0;
    logic [7:0]  avm_address;
    logic        avm_write, avm_read;
    logic [31:0] avm_writedata;
    logic [3:0]  avm_byteenable;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest = 1'b0;
    logic        busy, done, err;

    osd_row_writer dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_row(cmd_row), .cmd_sec(cmd_sec),
        .cmd_en(cmd_en), .cmd_hilite(cmd_hilite), .cmd_refresh(cmd_refresh),
        .char_valid(char_valid), .char_ready(char_ready), .char_data(char_data),
        .avm_address(avm_address), .avm_write(avm_write), .avm_read(avm_read),
        .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
        .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk_i = ~clk_i;

    int          n_tests = 0;
    int          n_fail = 0;
    logic [31:0] mem [0:255];
    logic [39:0] wr_log [$];
    logic [39:0] exp_q [$];
    logic [7:0]  char_q [$];
    logic [7:0]  ch_buf [16];
    int          stall_n = 0;
    bit          char_toggle = 1'b0;
    int          done_cnt = 0, err_cnt = 0, bus_cnt = 0;

    assign avm_readdata = mem[avm_address];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Slave model: evaluated on the falling edge, so every decision holds for the next rising edge.
    bit          in_xfer = 1'b0, prev_stall = 1'b0;
    int          stall_left = 0;
    logic [7:0]  p_addr;
    logic [31:0] p_data;
    logic [1:0]  p_ctl;
    always @(negedge clk_i) begin
        if (prev_stall && rst_ni) begin
            check("stall_addr", 64'(avm_address), 64'(p_addr));
            check("stall_ctl", 64'({avm_read, avm_write}), 64'(p_ctl));
            check("stall_wdata", 64'(avm_writedata), 64'(p_data));
        end
        if (avm_read || avm_write) begin
            bus_cnt++;
            check("rd_wr_exclusive", 64'(avm_read & avm_write), 64'd0);
            check("byteenable", 64'(avm_byteenable), 64'hF);
            if (!in_xfer) begin
                in_xfer    = 1'b1;
                stall_left = stall_n;
            end
            if (stall_left > 0) begin
                avm_waitrequest = 1'b1;
                stall_left--;
            end else begin
                avm_waitrequest = 1'b0;
                in_xfer = 1'b0;
                if (avm_write) begin
                    mem[avm_address] = avm_writedata;
                    wr_log.push_back({avm_address, avm_writedata});
                end
            end
        end else begin
            in_xfer = 1'b0;
            avm_waitrequest = 1'b0;
        end
        prev_stall = rst_ni && (avm_read || avm_write) && avm_waitrequest;
        p_addr = avm_address;
        p_data = avm_writedata;
        p_ctl  = {avm_read, avm_write};
        if (done) begin
            done_cnt++;
            check("busy_low_at_done", 64'(busy), 64'd0);
        end
        if (err) begin
            err_cnt++;
            check("ready_during_err", 64'(cmd_ready), 64'd1);
        end
    end

    // Character driver: an offer made while char_ready is high is taken at the next rising edge.
    bit ch_pend = 1'b0, ch_tog = 1'b0;
    always @(negedge clk_i) begin
        if (ch_pend && char_q.size() > 0) void'(char_q.pop_front());
        ch_tog = ~ch_tog;
        if (char_q.size() > 0 && (!char_toggle || ch_tog)) begin
            char_valid = 1'b1;
            char_data  = char_q[0];
        end else begin
            char_valid = 1'b0;
            char_data  = 8'($urandom);
        end
        ch_pend = char_valid && char_ready && rst_ni;
    end

    function automatic logic [31:0] with_bit(input logic [31:0] old, input int idx, input logic v);
        logic [31:0] m;
        m = 32'd1 << idx;
        return v ? (old | m) : (old & ~m);
    endfunction

    task automatic fill_chars(input bit seq);
        for (int k = 0; k < 16; k++) ch_buf[k] = seq ? 8'(8'h41 + k) : 8'($urandom);
    endtask

    task automatic check_reset_outputs(input string tag);
        check(tag, 64'({cmd_ready, char_ready, avm_write, avm_read, avm_address, avm_writedata,
                        avm_byteenable, busy, done, err}), 64'd0);
    endtask

    task automatic run_op(input string tag, input logic [4:0] row, input logic sec, input logic en,
                          input logic hil, input logic rf, input int stall, input bit tog,
                          input int abort_after);
        logic [31:0] w;
        logic [7:0]  a;
        bit          seen;
        stall_n = stall;
        char_toggle = tog;
        wr_log.delete();
        exp_q.delete();
        done_cnt = 0;
        err_cnt = 0;
        for (int wi = 0; wi < 4; wi++) begin
            w = 32'd0;
            for (int b = 0; b < 4; b++) w = w + (32'(ch_buf[wi*4 + b]) << (8*b));
            a = 8'(int'(row) * WORDS_PER_ROW + int'(sec) * 4 + wi);
            exp_q.push_back({a, w});
        end
        a = sec ? RSEC_EN_ADDR : LSEC_EN_ADDR;
        exp_q.push_back({a, with_bit(mem[a], int'(row), en)});
        exp_q.push_back({COLOR_ADDR, with_bit(mem[COLOR_ADDR], int'(row), hil)});
        if (rf) exp_q.push_back({CFG_ADDR, mem[CFG_ADDR] | 32'h2});
        for (int k = 0; k < 16; k++) char_q.push_back(ch_buf[k]);

        @(negedge clk_i);
        check({tag, "_ready_idle"}, 64'(cmd_ready), 64'd1);
        cmd_valid = 1'b1; cmd_row = row; cmd_sec = sec; cmd_en = en;
        cmd_hilite = hil; cmd_refresh = rf;
        seen = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk_i);
            if (c == 0) check({tag, "_busy"}, 64'(busy), 64'd1);
            if (abort_after >= 0 && wr_log.size() >= abort_after) begin
                @(posedge clk_i);
                #1 rst_ni = 1'b0;
                cmd_valid = 1'b0;
                #1 check_reset_outputs({tag, "_abort_outputs"});
                char_q.delete();
                repeat (3) @(negedge clk_i);
                check_reset_outputs({tag, "_held_outputs"});
                rst_ni = 1'b1;
                return;
            end
            if (done) begin
                seen = 1'b1;
                break;
            end
            cmd_valid = 1'($urandom_range(0, 1));
            cmd_row = 5'($urandom);
            cmd_sec = 1'($urandom); cmd_en = 1'($urandom);
            cmd_hilite = 1'($urandom); cmd_refresh = 1'($urandom);
        end
        cmd_valid = 1'b0;
        check({tag, "_done_seen"}, 64'(seen), 64'd1);
        repeat (2) @(negedge clk_i);
        check({tag, "_done_count"}, 64'(done_cnt), 64'd1);
        check({tag, "_no_err"}, 64'(err_cnt), 64'd0);
        check({tag, "_ready_after"}, 64'(cmd_ready), 64'd1);
        check({tag, "_chars_left"}, 64'(char_q.size()), 64'd0);
        check({tag, "_write_count"}, 64'(wr_log.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < wr_log.size()) check($sformatf("%s_wr%0d", tag, i), 64'(wr_log[i]), 64'(exp_q[i]));
        end
    endtask

    task automatic run_invalid(input string tag, input logic [4:0] row);
        err_cnt = 0; bus_cnt = 0; done_cnt = 0;
        for (int k = 0; k < 4; k++) char_q.push_back(8'($urandom));
        @(negedge clk_i);
        cmd_valid = 1'b1; cmd_row = row;
        @(negedge clk_i);
        cmd_valid = 1'b0;
        check({tag, "_err_pulse"}, 64'(err), 64'd1);
        repeat (5) @(negedge clk_i);
        check({tag, "_err_count"}, 64'(err_cnt), 64'd1);
        check({tag, "_bus_cycles"}, 64'(bus_cnt), 64'd0);
        check({tag, "_no_done"}, 64'(done_cnt), 64'd0);
        check({tag, "_chars_kept"}, 64'(char_q.size()), 64'd4);
        check({tag, "_ready"}, 64'(cmd_ready), 64'd1);
        char_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (observed timeout, required completion)");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] r;
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        rst_ni = 1'b0;
        repeat (3) @(negedge clk_i);
        check_reset_outputs("reset_outputs");
        rst_ni = 1'b1;
        @(negedge clk_i);
        check("ready_after_reset", 64'(cmd_ready), 64'd1);

        mem[LSEC_EN_ADDR] = 32'h1;
        mem[COLOR_ADDR]   = 32'h4;
        fill_chars(1'b1);
        run_op("left", 5'd2, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0, -1);
        check("left_char0", 64'(mem[8'h10]), 64'h44434241);
        check("left_char3", 64'(mem[8'h13]), 64'h504F4E4D);
        check("left_en", 64'(mem[LSEC_EN_ADDR]), 64'h5);
        check("left_color", 64'(mem[COLOR_ADDR]), 64'h0);

        mem[CFG_ADDR] = 32'h5;
        fill_chars(1'b0);
        run_op("right_refresh", 5'd29, 1'b1, 1'b1, 1'b1, 1'b1, 0, 1'b0, -1);
        check("right_cfg", 64'(mem[CFG_ADDR]), 64'h7);
        check("right_en_bit", 64'(mem[RSEC_EN_ADDR][29]), 64'd1);
        check("right_color_bit", 64'(mem[COLOR_ADDR][29]), 64'd1);

        mem[LSEC_EN_ADDR] = 32'hFFFF_FFFF;
        fill_chars(1'b0);
        run_op("clear_en", 5'd0, 1'b0, 1'b0, 1'($urandom), 1'b0, 0, 1'b0, -1);
        check("clear_en_value", 64'(mem[LSEC_EN_ADDR]), 64'hFFFF_FFFE);

        run_invalid("row30", 5'd30);
        run_invalid("row31", 5'd31);

        fill_chars(1'b0);
        run_op("stall", 5'd7, 1'b1, 1'b0, 1'b1, 1'b1, 3, 1'b1, -1);

        fill_chars(1'b0);
        run_op("abort", 5'd11, 1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b0, 2);
        fill_chars(1'b0);
        run_op("post_abort", 5'd12, 1'b1, 1'b1, 1'b0, 1'b1, 1, 1'b0, -1);

        for (int t = 0; t < 8; t++) begin
            r = 5'($urandom_range(0, CHAR_ROWS - 1));
            for (int i = 0; i < 4; i++) mem[CFG_ADDR + 8'(i)] = $urandom;
            fill_chars(1'b0);
            run_op($sformatf("rand%0d", t), r, 1'($urandom), 1'($urandom), 1'($urandom),
                   1'($urandom), $urandom_range(0, 2), 1'($urandom), -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
